// File: rtl/fx_gate_env_ctrl_if.sv
// Sample/parameter bus into the gate envelope controller and gain/state bus back out.
`default_nettype none

interface fx_gate_env_ctrl_if #(
  parameter int DATA_W  = 16,
  parameter int PARAM_W = 7,
  parameter int GAIN_W  = 8
);
  logic                          sample_valid_i;
  logic [1:0][DATA_W-1:0]        audio_in_i;
  logic [PARAM_W-1:0]            threshold_i;
  logic [PARAM_W-1:0]            attack_i;
  logic [PARAM_W-1:0]            release_i;
  logic [GAIN_W-1:0]             gain_o;
  logic                          gain_valid_o;
  logic                          gate_open_o;
  logic [1:0]                    state_o;

  modport master (
    output sample_valid_i, audio_in_i, threshold_i, attack_i, release_i,
    input  gain_o, gain_valid_o, gate_open_o, state_o
  );

  modport slave (
    input  sample_valid_i, audio_in_i, threshold_i, attack_i, release_i,
    output gain_o, gain_valid_o, gate_open_o, state_o
  );
endinterface

`default_nettype wire

// File: rtl/fx_gate_env_ctrl.sv
// Stereo noise-gate envelope: peak detect, threshold compare, CLOSED/ATTACK/OPEN/RELEASE gain ramp.
// Define FX_GATE_HYST_EN to make the OPEN hold decision use a threshold 6 dB below the open point.
`default_nettype none

module fx_gate_env_ctrl #(
  parameter int DATA_W       = 16,
  parameter int PARAM_W      = 7,
  parameter int GAIN_W       = 8,
  parameter int HOLD_SAMPLES = 480
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fx_gate_env_ctrl_if.slave bus
);
  localparam int                SHIFT     = DATA_W - 1 - PARAM_W;
  localparam int                HOLD_W    = $clog2(HOLD_SAMPLES + 1);
  localparam logic [GAIN_W-1:0] GAIN_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_SAMPLES);

  localparam logic [1:0] ST_CLOSED  = 2'b00;
  localparam logic [1:0] ST_ATTACK  = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;
  localparam logic [1:0] ST_RELEASE = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic [PARAM_W-1:0] presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               valid_q;

  // Magnitude with the most negative code clamped to the largest positive one.
  function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1])       return x[DATA_W-2:0];
    else if (neg[DATA_W-1]) return '1;
    else                    return neg[DATA_W-2:0];
  endfunction

  logic [DATA_W-2:0]  abs_l, abs_r, lvl, thr_open;
  logic               above, above_close, step;
  logic [PARAM_W-1:0] step_param;

  assign abs_l    = sat_abs(bus.audio_in_i[0]);
  assign abs_r    = sat_abs(bus.audio_in_i[1]);
  assign lvl      = (abs_l > abs_r) ? abs_l : abs_r;
  assign thr_open = (DATA_W-1)'(bus.threshold_i) << SHIFT;
  assign above    = (lvl >= thr_open);
`ifdef FX_GATE_HYST_EN
  assign above_close = (lvl >= (thr_open >> 1));
`else
  assign above_close = above;
`endif

  assign step_param = (state_q == ST_RELEASE) ? bus.release_i : bus.attack_i;
  assign step       = (presc_q >= step_param);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLOSED;
      gain_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      valid_q <= bus.sample_valid_i;
    end
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    if (bus.sample_valid_i) begin
      case (state_q)
        ST_CLOSED: begin
          gain_d  = '0;
          presc_d = '0;
          if (above) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (gain_q == GAIN_MAX) begin
            state_d = ST_OPEN;
            hold_d  = HOLD_INIT;
            presc_d = '0;
          end else if (step) begin
            gain_d  = gain_q + GAIN_W'(1);
            presc_d = '0;
            if (gain_q == GAIN_MAX - GAIN_W'(1)) begin
              state_d = ST_OPEN;
              hold_d  = HOLD_INIT;
            end
          end else begin
            presc_d = presc_q + PARAM_W'(1);
          end
        end
        ST_OPEN: begin
          gain_d  = GAIN_MAX;
          presc_d = '0;
          if (above_close) begin
            hold_d = HOLD_INIT;
          end else begin
            hold_d = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
            if (hold_q <= HOLD_W'(1)) state_d = ST_RELEASE;
          end
        end
        default: begin
          // Re-triggering resumes the ramp from the current gain instead of restarting it.
          if (above) begin
            state_d = ST_ATTACK;
            presc_d = '0;
          end else if (gain_q == '0) begin
            state_d = ST_CLOSED;
            presc_d = '0;
          end else if (step) begin
            gain_d  = gain_q - GAIN_W'(1);
            presc_d = '0;
            if (gain_q == GAIN_W'(1)) state_d = ST_CLOSED;
          end else begin
            presc_d = presc_q + PARAM_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.gain_o       = gain_q;
    bus.gain_valid_o = valid_q;
    bus.gate_open_o  = (state_q != ST_CLOSED);
    bus.state_o      = state_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fx_gate_env_ctrl.sv
// Scoreboard bench for fx_gate_env_ctrl: a behavioural envelope model predicts each gain/state update.
`default_nettype none

module tb_fx_gate_env_ctrl;
  localparam int DATA_W  = 16;
  localparam int PARAM_W = 7;
  localparam int GAIN_W  = 8;
  localparam int HOLD    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fx_gate_env_ctrl_if #(.DATA_W(DATA_W), .PARAM_W(PARAM_W), .GAIN_W(GAIN_W)) bus ();

  fx_gate_env_ctrl #(
    .DATA_W(DATA_W), .PARAM_W(PARAM_W), .GAIN_W(GAIN_W), .HOLD_SAMPLES(HOLD)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct { int gain; int state; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int m_state, m_gain, m_presc, m_hold;
  int cur_thr, cur_att, cur_rel;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int mag(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  task automatic model_reset();
    m_state = 0; m_gain = 0; m_presc = 0; m_hold = 0;
  endtask

  task automatic model_step(input int l, input int r);
    int lvl, thr, above, above_close;
    lvl   = (mag(l) > mag(r)) ? mag(l) : mag(r);
    thr   = cur_thr * 256;
    above = (lvl >= thr);
`ifdef FX_GATE_HYST_EN
    above_close = (lvl >= thr / 2);
`else
    above_close = above;
`endif
    case (m_state)
      0: begin
        m_gain = 0; m_presc = 0;
        if (above) m_state = 1;
      end
      1: begin
        if (m_presc >= cur_att) begin
          m_presc = 0;
          if (m_gain < 255) m_gain++;
        end else m_presc++;
        if (m_gain == 255) begin m_state = 2; m_hold = HOLD; m_presc = 0; end
      end
      2: begin
        m_gain = 255; m_presc = 0;
        if (above_close) m_hold = HOLD;
        else begin
          if (m_hold == 1) m_state = 3;
          m_hold--;
        end
      end
      default: begin
        if (above) begin m_state = 1; m_presc = 0; end
        else begin
          if (m_presc >= cur_rel) begin
            m_presc = 0;
            if (m_gain > 0) m_gain--;
          end else m_presc++;
          if (m_gain == 0) begin m_state = 0; m_presc = 0; end
        end
      end
    endcase
  endtask

  task automatic send(input int l, input int r);
    exp_t e;
    @(posedge clk); #1;
    bus.audio_in_i[0]  = l[DATA_W-1:0];
    bus.audio_in_i[1]  = r[DATA_W-1:0];
    bus.threshold_i    = cur_thr[PARAM_W-1:0];
    bus.attack_i       = cur_att[PARAM_W-1:0];
    bus.release_i      = cur_rel[PARAM_W-1:0];
    bus.sample_valid_i = 1'b1;
    model_step(l, r);
    e.gain = m_gain; e.state = m_state;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.sample_valid_i = 1'b0;
  endtask

  task automatic run_until_state(input int target, input int l, input int r, input int max_n);
    for (int i = 0; i < max_n && m_state != target; i++) send(l, r);
    @(negedge clk);
    check_val("reach_state", int'(bus.state_o), target);
  endtask

  task automatic run_until_gain(input int target, input int l, input int r, input int max_n);
    for (int i = 0; i < max_n && m_gain != target; i++) send(l, r);
    @(negedge clk);
    check_val("reach_gain", int'(bus.gain_o), target);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.gain_valid_o) begin
      if (sb_q.size() == 0) begin
        check_val("sb_extra_valid", int'(bus.gain_valid_o), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("gain", int'(bus.gain_o), e.gain);
        check_val("state", int'(bus.state_o), e.state);
        check_val("gate_open", int'(bus.gate_open_o), int'(e.state != 0));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.sample_valid_i = 1'b0;
    bus.audio_in_i     = '0;
    bus.threshold_i    = '0;
    bus.attack_i       = '0;
    bus.release_i      = '0;
    cur_thr = 10; cur_att = 0; cur_rel = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_gain", int'(bus.gain_o), 0);
    check_val("rst_state", int'(bus.state_o), 0);
    check_val("rst_valid", int'(bus.gain_valid_o), 0);
    check_val("rst_open", int'(bus.gate_open_o), 0);
    reset = 1'b0;

    // Silence stays closed
    repeat (10) send(0, 0);
    // Loud left channel ramps fully open at one step per sample
    run_until_state(2, 3000, 0, 300);
    check_val("open_gain", int'(bus.gain_o), 255);
    // Silence: hold, then release at one step every two samples down to closed
    run_until_state(3, 0, 0, 10);
    run_until_state(0, 0, 0, 600);

    // Re-trigger from RELEASE at gain 100 with a saturating negative right sample
    run_until_state(2, 3000, 0, 300);
    run_until_gain(100, 0, 0, 400);
    send(0, -32768);
    repeat (3) send(3000, 0);
    @(negedge clk);
    check_val("retrig_gain", int'(bus.gain_o), 103);

    // Attack prescale lowered mid-ramp takes effect at once
    cur_att = 5;
    repeat (3) send(3000, 0);
    cur_att = 1;
    repeat (4) send(3000, 0);
    cur_att = 0;
    run_until_state(2, 3000, 0, 300);

    // Level between open and half-open point
    repeat (10) send(1500, 0);
    cur_rel = 0;
    run_until_state(0, 0, 0, 300);

    // Threshold zero opens on silence; then reset mid-attack with idle gaps
    cur_thr = 0;
    run_until_gain(50, 0, 0, 100);
    @(negedge clk);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check_val("gap_gain", int'(bus.gain_o), m_gain);
      check_val("gap_state", int'(bus.state_o), m_state);
      check_val("gap_valid", int'(bus.gain_valid_o), 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_gain", int'(bus.gain_o), 0);
    check_val("midrst_state", int'(bus.state_o), 0);
    check_val("midrst_valid", int'(bus.gain_valid_o), 0);
    reset = 1'b0;
    model_reset();
    cur_thr = 10;
    repeat (3) send(100, -100);

    repeat (4) @(posedge clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
